matrix_scan_decoder: RTL and testbench
======================================

# matrix_scan_decoder

Receive-side decoder for the multiplexed 5-column × 8-row LED matrix scan bus (`colunas`/`linhas`) driven by the game top level through the `matriz` scanner. It samples the scan signals, deglitches column selects, and rebuilds a full 40-bit frame image. Each completed frame is published with a one-cycle strobe. Its consumers are board-level self-test, the seven-segment debug path and the simulation scoreboard.

## Interface
- `STABLE_CYCLES`, 4: consecutive identical column-select samples required before a capture; must be ≥1.
- `TIMEOUT_CYCLES`, 4096: cycles without any capture before the scan is declared lost.
- `CNT_W`, 8: width of the frame counter.

- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `colunas`  in  5  column select, active-high, one-hot during normal scan.
- `linhas`  in  8  row data for the selected column, active-low (0 = LED lit).
- `frame`  out  40  last complete frame. Column c occupies bits [8c+7:8c]; 1 = lit.
- `frame_valid`  out  1  one-cycle pulse when `frame` updates.
- `frame_cnt`  out  CNT_W  completed-frame count; wraps to 0.
- `cur_col`  out  3  index of the last captured column; 0 after reset.
- `err_multi`  out  1  one-cycle pulse on a stable multi-hot select other than all-ones.
- `scan_lost`  out  1  level; high in the LOST state.

## Operation
- Input stage: `colunas` and `linhas` are registered once. All later logic uses the registered copies.
- Stability counter:
  - Increments while the registered select equals its previous value. Saturates at `STABLE_CYCLES`.
  - Reloads to 1 on any change.
  - A capture is evaluated only on the cycle the counter first reaches `STABLE_CYCLES`. This gives one evaluation per stable run; holding a select longer never re-captures.
- Classification of a stable select value:
  - One-hot: write `~linhas` into shadow column c, set `seen[c]`, set `cur_col` = c.
  - 5'b11111 (broadcast/flash): write `~linhas` into all five shadow columns and set `seen` to all-ones.
  - 5'b00000 (blank): no capture and no error. The timeout keeps running.
  - Any other multi-hot value: pulse `err_multi`. No capture; `seen` is unchanged.
- Frame completion: when `seen` becomes all-ones:
  - copy shadow to `frame`;
  - pulse `frame_valid`;
  - increment `frame_cnt`;
  - clear `seen`.
- A repeated column before completion overwrites its shadow column. This is not an error.
- States:
  - LOST: reset state; `scan_lost`=1. The first capture moves to TRACK.
  - TRACK: the timeout counter clears on every capture. When it reaches `TIMEOUT_CYCLES` the block returns to LOST, clears `seen`, and discards the partial shadow. `frame` and `frame_cnt` are retained.
- A capture in LOST counts toward the new frame.

## Timing
- Reset values:
  - `frame`=0, `frame_valid`=0, `frame_cnt`=0, `cur_col`=0, `err_multi`=0, `scan_lost`=1.
  - Internal: `seen`=0, shadow=0, counters=0.
- Let edge E be the edge at which the input register receives the `STABLE_CYCLES`-th consecutive identical select.
  - Capture occurs at edge E+1, using the `linhas` value registered at E.
  - `cur_col`, `err_multi` and the exit from LOST (`scan_lost` falls) all occur at E+1.
  - `frame`, `frame_valid` and `frame_cnt` update at E+2.
- `frame_valid` is never high on two consecutive cycles.
- `rst` asserted mid-frame discards everything on the next edge. No strobe is emitted for the partial frame.
- Timeout and capture in the same cycle: the capture wins, the timeout counter clears, and the state stays TRACK.
- `frame_cnt` wraps from 2^CNT_W−1 to 0 without a flag.

## Structure
- Package `scan_pkg` holds:
  - `NUM_COLS`=5, `NUM_ROWS`=8;
  - the state encoding (`ST_LOST`, `ST_TRACK`);
  - the broadcast constant `COL_ALL`=5'b11111.
- Sub-module `scan_col_sampler` contains the input registers and the stability counter. It outputs a one-cycle `cap` strobe with the registered select and row data.
- The top level holds the classifier, shadow, seen mask, FSM and output registers.

## Test plan
- In-order scan: drive columns 0..4 in order, each held 10 cycles, with `linhas` = 8'hFE, FD, FB, F7, EF. Required: exactly one `frame_valid`; `frame` = 40'h10_08_04_02_01; `frame_cnt`=1; `scan_lost`=0.
- Deglitch: hold a select for `STABLE_CYCLES`−1 cycles, then change it. Required: no capture, `cur_col` unchanged, no `frame_valid`.
- Multi-hot: stable select 5'b00011 for 10 cycles. Required: exactly one `err_multi` pulse and no change to `seen`. A subsequent full scan still yields one frame.
- Broadcast: `colunas`=5'b11111, `linhas`=8'h00, held 10 cycles. Required: `frame` = all ones (40 bits), one `frame_valid`, one frame count.
- Timeout: capture columns 0–2, then drive 5'b00000 for `TIMEOUT_CYCLES`+5 cycles. Required: `scan_lost` rises and the partial frame is discarded. A following full scan produces one frame whose contents come only from the new scan.
- Reset mid-frame: capture columns 0–3, then pulse `rst` for 1 cycle. Required: all outputs return to their reset values (`scan_lost`=1) and no `frame_valid` is emitted.

Source files
------------

// File: rtl/matrix_scan_decoder_pkg.sv
// Shared constants and state encoding for the LED matrix scan decoder.
package scan_pkg;

  localparam int unsigned NUM_COLS = 5;
  localparam int unsigned NUM_ROWS = 8;

  localparam logic [NUM_COLS-1:0] COL_ALL = 5'b11111;

  typedef enum logic {
    ST_LOST  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  function automatic logic [2:0] count_ones(input logic [NUM_COLS-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int unsigned i = 0; i < NUM_COLS; i++) begin
      if (v[i]) n = n + 3'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/scan_col_sampler.sv
// Registers the scan bus once and emits a single capture strobe per stable
// column-select run of STABLE_CYCLES identical samples.
module scan_col_sampler
  import scan_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NUM_COLS-1:0] i_col,
  input  logic [NUM_ROWS-1:0] i_row,
  output logic                o_cap,
  output logic [NUM_COLS-1:0] o_col,
  output logic [NUM_ROWS-1:0] o_row
);

  localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
  localparam logic [SW-1:0] STABLE_V = SW'(STABLE_CYCLES);

  logic [NUM_COLS-1:0] r_col;
  logic [NUM_ROWS-1:0] r_row;
  logic [SW-1:0]       r_cnt;
  logic                r_cap;

  logic                w_same;
  logic [SW-1:0]       w_cnt_next;
  logic                w_hit;

  // The counter tracks the value being loaded into r_col, so it reaches
  // STABLE_CYCLES on the same edge that registers the last required sample.
  always_comb begin
    w_same     = (i_col == r_col);
    w_cnt_next = SW'(1);
    if (w_same) begin
      w_cnt_next = (r_cnt == STABLE_V) ? r_cnt : r_cnt + SW'(1);
    end
    w_hit = (w_cnt_next == STABLE_V) && (!w_same || (r_cnt != STABLE_V));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_col <= '0;
      r_row <= '0;
      r_cnt <= '0;
      r_cap <= 1'b0;
    end else begin
      r_col <= i_col;
      r_row <= i_row;
      r_cnt <= w_cnt_next;
      r_cap <= w_hit;
    end
  end

  assign o_cap = r_cap;
  assign o_col = r_col;
  assign o_row = r_row;

endmodule

// File: rtl/matrix_scan_decoder.sv
// Rebuilds 5x8 LED matrix frames from the multiplexed column/row scan bus
// and publishes each complete frame with a one-cycle strobe.
module matrix_scan_decoder
  import scan_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_COLS-1:0]          colunas,
  input  logic [NUM_ROWS-1:0]          linhas,
  output logic [NUM_COLS*NUM_ROWS-1:0] frame,
  output logic                         frame_valid,
  output logic [CNT_W-1:0]             frame_cnt,
  output logic [2:0]                   cur_col,
  output logic                         err_multi,
  output logic                         scan_lost
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_V = TW'(TIMEOUT_CYCLES);

  logic                         w_cap;
  logic [NUM_COLS-1:0]          w_col;
  logic [NUM_ROWS-1:0]          w_row;

  state_t                       r_state, w_state_next;
  logic [TW-1:0]                r_to;
  logic [NUM_COLS-1:0]          r_seen;
  logic [NUM_COLS*NUM_ROWS-1:0] r_shadow;
  logic [NUM_COLS*NUM_ROWS-1:0] r_frame;
  logic                         r_frame_valid;
  logic [CNT_W-1:0]             r_frame_cnt;
  logic [2:0]                   r_cur_col;
  logic                         r_err;

  logic [2:0]                   w_ones;
  logic [2:0]                   w_idx;
  logic                         w_cap_one;
  logic                         w_cap_all;
  logic                         w_cap_err;
  logic                         w_capture;
  logic [NUM_COLS-1:0]          w_mask;
  logic                         w_timeout;
  logic                         w_complete;
  logic [NUM_COLS-1:0]          w_seen_base;

  scan_col_sampler #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_sampler (
    .i_clk (clk),
    .i_rst (rst),
    .i_col (colunas),
    .i_row (linhas),
    .o_cap (w_cap),
    .o_col (w_col),
    .o_row (w_row)
  );

  always_comb begin
    w_ones = count_ones(w_col);
    w_idx  = '0;
    for (int unsigned c = 0; c < NUM_COLS; c++) begin
      if (w_col[c]) w_idx = 3'(c);
    end
    w_cap_all = w_cap && (w_col == COL_ALL);
    w_cap_one = w_cap && (w_ones == 3'd1);
    w_cap_err = w_cap && (w_ones > 3'd1) && !w_cap_all;
    w_capture = w_cap_one || w_cap_all;
    w_mask    = w_cap_all ? '1 : (w_cap_one ? w_col : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_LOST;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_timeout    = 1'b0;
    case (r_state)
      ST_LOST:  if (w_capture) w_state_next = ST_TRACK;
      ST_TRACK: begin
        if (!w_capture && (r_to == TO_V)) begin
          w_timeout    = 1'b1;
          w_state_next = ST_LOST;
        end
      end
      default:  w_state_next = ST_LOST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || w_capture || w_timeout || (r_state == ST_LOST)) r_to <= '0;
    else if (r_to != TO_V)                                      r_to <= r_to + TW'(1);
  end

  // Holding completion off for one cycle after a strobe keeps frame_valid
  // from ever asserting on back-to-back cycles.
  always_comb begin
    w_complete  = (r_seen == '1) && !r_frame_valid;
    w_seen_base = (w_complete || w_timeout) ? '0 : r_seen;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seen        <= '0;
      r_frame       <= '0;
      r_frame_valid <= 1'b0;
      r_frame_cnt   <= '0;
      r_cur_col     <= '0;
      r_err         <= 1'b0;
    end else begin
      r_seen        <= w_seen_base | w_mask;
      r_frame_valid <= w_complete;
      r_err         <= w_cap_err;
      if (w_complete) begin
        r_frame     <= r_shadow;
        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      end
      if (w_cap_one) r_cur_col <= w_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_timeout) begin
      r_shadow <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_COLS; c++) begin
        if (w_mask[c]) r_shadow[c*NUM_ROWS +: NUM_ROWS] <= ~w_row;
      end
    end
  end

  assign frame       = r_frame;
  assign frame_valid = r_frame_valid;
  assign frame_cnt   = r_frame_cnt;
  assign cur_col     = r_cur_col;
  assign err_multi   = r_err;
  assign scan_lost   = (r_state == ST_LOST);

endmodule

// File: tb/tb_matrix_scan_decoder.sv
// Directed vector bench for matrix_scan_decoder: table-driven scan steps
// plus hand-written timeout, reset and counter-wrap sequences.
module tb_matrix_scan_decoder;

  localparam int unsigned STABLE  = 4;
  localparam int unsigned TIMEOUT = 4096;

  logic        clk;
  logic        rst;
  logic [4:0]  colunas;
  logic [7:0]  linhas;
  logic [39:0] frame;
  logic        frame_valid;
  logic [7:0]  frame_cnt;
  logic [2:0]  cur_col;
  logic        err_multi;
  logic        scan_lost;

  int checks   = 0;
  int failures = 0;
  int vcnt     = 0;
  int ecnt     = 0;
  logic prev_v = 1'b0;

  matrix_scan_decoder #(
    .STABLE_CYCLES (STABLE),
    .TIMEOUT_CYCLES(TIMEOUT),
    .CNT_W         (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .colunas    (colunas),
    .linhas     (linhas),
    .frame      (frame),
    .frame_valid(frame_valid),
    .frame_cnt  (frame_cnt),
    .cur_col    (cur_col),
    .err_multi  (err_multi),
    .scan_lost  (scan_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Pulse counting and back-to-back strobe check, sampled 2ns after each edge.
  always begin
    @(posedge clk);
    #2;
    if (frame_valid) begin
      vcnt++;
      chk("valid_not_consecutive", {63'd0, prev_v}, 64'd0);
    end
    if (err_multi) ecnt++;
    prev_v = frame_valid;
  end

  // Called at a negedge; the values are sampled by exactly n rising edges.
  task automatic apply(input logic [4:0] c, input logic [7:0] r, input int n);
    colunas = c;
    linhas  = r;
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [4:0]  col;
    logic [7:0]  row;
    int          hold;
    logic [2:0]  cur;
    logic        lost;
    int          nv;
    int          ne;
    logic [39:0] frm;
    logic [7:0]  cnt;
  } vec_t;

  vec_t tbl[17];
  int   vbase;

  initial begin
    tbl[0]  = '{5'h01, 8'hFE, 10, 3'd0, 1'b0, 0, 0, 40'h0, 8'd0};
    tbl[1]  = '{5'h02, 8'hFD, 10, 3'd1, 1'b0, 0, 0, 40'h0, 8'd0};
    tbl[2]  = '{5'h04, 8'hFB, 10, 3'd2, 1'b0, 0, 0, 40'h0, 8'd0};
    tbl[3]  = '{5'h08, 8'hF7, 10, 3'd3, 1'b0, 0, 0, 40'h0, 8'd0};
    tbl[4]  = '{5'h10, 8'hEF, 10, 3'd4, 1'b0, 1, 0, 40'h10_08_04_02_01, 8'd1};
    tbl[5]  = '{5'h01, 8'h0F, 10, 3'd0, 1'b0, 1, 0, 40'h10_08_04_02_01, 8'd1};
    tbl[6]  = '{5'h02, 8'hF0, 10, 3'd1, 1'b0, 1, 0, 40'h10_08_04_02_01, 8'd1};
    tbl[7]  = '{5'h04, 8'h55, 10, 3'd2, 1'b0, 1, 0, 40'h10_08_04_02_01, 8'd1};
    tbl[8]  = '{5'h18, 8'h00, 10, 3'd2, 1'b0, 1, 1, 40'h10_08_04_02_01, 8'd1};
    tbl[9]  = '{5'h08, 8'hAA, 10, 3'd3, 1'b0, 1, 1, 40'h10_08_04_02_01, 8'd1};
    tbl[10] = '{5'h10, 8'h00, 10, 3'd4, 1'b0, 2, 1, 40'hFF_55_AA_0F_F0, 8'd2};
    tbl[11] = '{5'h1F, 8'h00, 10, 3'd4, 1'b0, 3, 1, 40'hFF_FF_FF_FF_FF, 8'd3};
    tbl[12] = '{5'h04, 8'h00, STABLE-1, 3'd4, 1'b0, 3, 1, 40'hFF_FF_FF_FF_FF, 8'd3};
    tbl[13] = '{5'h02, 8'h00, STABLE-1, 3'd4, 1'b0, 3, 1, 40'hFF_FF_FF_FF_FF, 8'd3};
    tbl[14] = '{5'h00, 8'hFF, 10, 3'd4, 1'b0, 3, 1, 40'hFF_FF_FF_FF_FF, 8'd3};
    tbl[15] = '{5'h02, 8'h7E, STABLE, 3'd4, 1'b0, 3, 1, 40'hFF_FF_FF_FF_FF, 8'd3};
    tbl[16] = '{5'h00, 8'hFF, 5, 3'd1, 1'b0, 3, 1, 40'hFF_FF_FF_FF_FF, 8'd3};

    rst = 1'b1; colunas = '0; linhas = 8'hFF;
    repeat (3) @(negedge clk);
    chk("rst_frame", {24'd0, frame}, 64'd0);
    chk("rst_valid", {63'd0, frame_valid}, 64'd0);
    chk("rst_cnt",   {56'd0, frame_cnt}, 64'd0);
    chk("rst_cur",   {61'd0, cur_col}, 64'd0);
    chk("rst_err",   {63'd0, err_multi}, 64'd0);
    chk("rst_lost",  {63'd0, scan_lost}, 64'd1);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 17; i++) begin
      apply(tbl[i].col, tbl[i].row, tbl[i].hold);
      chk($sformatf("step%0d_cur", i),   {61'd0, cur_col}, {61'd0, tbl[i].cur});
      chk($sformatf("step%0d_lost", i),  {63'd0, scan_lost}, {63'd0, tbl[i].lost});
      chk($sformatf("step%0d_nvalid", i), 64'(vcnt), 64'(tbl[i].nv));
      chk($sformatf("step%0d_nerr", i),  64'(ecnt), 64'(tbl[i].ne));
      chk($sformatf("step%0d_frame", i), {24'd0, frame}, {24'd0, tbl[i].frm});
      chk($sformatf("step%0d_cnt", i),   {56'd0, frame_cnt}, {56'd0, tbl[i].cnt});
    end

    // Timeout: partial scan, then blank long enough to lose the scan.
    apply(5'h01, 8'h00, 10);
    apply(5'h02, 8'h00, 10);
    apply(5'h04, 8'h00, 10);
    chk("to_pre_lost", {63'd0, scan_lost}, 64'd0);
    apply(5'h00, 8'hFF, TIMEOUT + 5);
    chk("to_lost",   {63'd0, scan_lost}, 64'd1);
    chk("to_frame",  {24'd0, frame}, {24'd0, 40'hFF_FF_FF_FF_FF});
    chk("to_cnt",    {56'd0, frame_cnt}, 64'd3);
    chk("to_nvalid", 64'(vcnt), 64'd3);
    apply(5'h08, 8'hFE, 10);
    chk("to_relock", {63'd0, scan_lost}, 64'd0);
    apply(5'h10, 8'hFD, 10);
    chk("to_no_early_frame", 64'(vcnt), 64'd3);
    apply(5'h01, 8'hFB, 10);
    apply(5'h02, 8'hF7, 10);
    apply(5'h04, 8'hEF, 10);
    chk("to_new_nvalid", 64'(vcnt), 64'd4);
    chk("to_new_frame",  {24'd0, frame}, {24'd0, 40'h02_01_10_08_04});
    chk("to_new_cnt",    {56'd0, frame_cnt}, 64'd4);
    chk("to_new_cur",    {61'd0, cur_col}, 64'd2);

    // Reset mid-frame.
    apply(5'h01, 8'h00, 10);
    apply(5'h02, 8'h00, 10);
    apply(5'h04, 8'h00, 10);
    apply(5'h08, 8'h00, 10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_frame", {24'd0, frame}, 64'd0);
    chk("mrst_valid", {63'd0, frame_valid}, 64'd0);
    chk("mrst_cnt",   {56'd0, frame_cnt}, 64'd0);
    chk("mrst_cur",   {61'd0, cur_col}, 64'd0);
    chk("mrst_err",   {63'd0, err_multi}, 64'd0);
    chk("mrst_lost",  {63'd0, scan_lost}, 64'd1);
    apply(5'h10, 8'h00, 10);
    apply(5'h00, 8'hFF, 10);
    chk("mrst_nvalid", 64'(vcnt), 64'd4);
    chk("mrst_cur4",   {61'd0, cur_col}, 64'd4);

    // Frame counter wrap via repeated broadcast frames.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vbase = vcnt;
    for (int i = 0; i < 256; i++) begin
      apply(5'h1F, 8'h00, 5);
      apply(5'h00, 8'hFF, 5);
      if (i == 254) chk("wrap_cnt255", {56'd0, frame_cnt}, 64'd255);
    end
    chk("wrap_cnt0",   {56'd0, frame_cnt}, 64'd0);
    chk("wrap_nvalid", 64'(vcnt - vbase), 64'd256);
    chk("wrap_frame",  {24'd0, frame}, {24'd0, 40'hFF_FF_FF_FF_FF});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
